ethernet_mmio_arbiter: RTL and testbench
========================================

# ethernet_mmio_arbiter

Two-requester arbiter and sequencer in front of the Ethernet MMIO decoder. It lets a host port and an on-chip agent share the decoder's single, un-handshaked MMIO port. The agent is, for example, a TX-descriptor engine. The block grants one access at a time, drives the decoder's read/write enables for exactly one cycle, and captures the decode error and the one-cycle-late read data. It then holds a response until the owning requester accepts it.

## Interface
Parameters:
- `data_width_p`, 32: MMIO data width; matches the decoder data width.
- `addr_width_p`, 16: MMIO address width.

Ports:
- `clk_i`  in  1: clock.
- `reset_n_i`  in  1: asynchronous, active-low reset.
- `req_v_i`  in  2: request valid, one bit per requester k.
- `req_ready_o`  out  2: request accepted this cycle (k).
- `req_we_i`  in  2: 1 = write, 0 = read (k).
- `req_lock_i`  in  2: keep the grant after this access (k).
- `req_addr_i`  in  2*addr_width_p: packed address; requester k uses slice k.
- `req_op_size_i`  in  4: packed 2-bit op size (k).
- `req_data_i`  in  2*data_width_p: packed write data (k).
- `resp_v_o`  out  2: response valid (k).
- `resp_ready_i`  in  2: response accepted (k).
- `resp_data_o`  out  data_width_p: response read data, shared by both requesters.
- `resp_err_o`  out  1: response decode error, shared.
- `dec_addr_o`, `dec_op_size_o`, `dec_write_data_o`  out  16/2/data_width_p: decoder request fields.
- `dec_write_en_o`, `dec_read_en_o`  out  1: decoder enables.
- `dec_read_data_i`  in  data_width_p: decoder read data.
- `dec_read_data_v_i`  in  1: LSB of the decoder read-valid output.
- `dec_error_i`  in  1: decoder decode error; combinational with the enables.

## Operation
- States:
  - IDLE: arbitrate and accept.
  - RD_WAIT: capture read data.
  - RESP: hold the response.
- In IDLE, the granted requester k is chosen as follows:
  - If a lock is held, k is the lock owner.
  - Otherwise, if only one `req_v_i` bit is set, k is that requester.
  - Otherwise (both set), k is the requester named by the round-robin pointer `rr_r`.
- On accept:
  - `req_ready_o[k]`=1.
  - `dec_*` fields are driven from slice k.
  - `dec_write_en_o`=`req_we_i[k]` and `dec_read_en_o`=~`req_we_i[k]`.
  - `owner_r`<=k and `rr_r`<=~k.
- Decoder outputs are 0 whenever no accept occurs; enables are never asserted outside IDLE.
- Write, or read with `dec_error_i`=1, at accept:
  - `err_r`<=`dec_error_i`, `data_r`<=0.
  - Next state RESP.
- Read without error at accept: next state RD_WAIT.
- In RD_WAIT (one cycle):
  - If `dec_read_data_v_i`=1: `data_r`<=`dec_read_data_i`, `err_r`<=0.
  - If `dec_read_data_v_i`=0: `data_r`<=0, `err_r`<=1.
  - Next state RESP.
- In RESP:
  - `resp_v_o[owner_r]`=1; the other bit is 0.
  - `resp_data_o`=`data_r`, `resp_err_o`=`err_r`.
  - On `resp_ready_i[owner_r]`, go to IDLE.
  - No new request is accepted in the same cycle.
- Lock (only when `ETH_MMIO_ARB_LOCK_EN` is defined):
  - On accept, `lock_v_r`<=`req_lock_i[k]`.
  - While `lock_v_r`=1, the other requester is never granted, even when the owner is idle.
  - The lock releases on the owner's next accepted request with `req_lock_i`=0.
  - The lock is not released by the response handshake.
- Simultaneous requests in IDLE with `rr_r`=0 and no lock: requester 0 wins and requester 1 waits.
- A requester must hold its request fields stable while `req_v_i` is high and `req_ready_o` is low.

## Timing
- Values during reset (`reset_n_i`=0), applied asynchronously:
  - state=IDLE, `rr_r`=0, `owner_r`=0, `lock_v_r`=0, `data_r`=0, `err_r`=0.
  - All `resp_v_o`, `req_ready_o` and `dec_*` outputs are 0.
- Deassertion of `reset_n_i` is synchronised to `clk_i` outside this block.
- Reset mid-access: any pending response is discarded; the decoder sees no further enables.
- `req_ready_o` is combinational from state, lock and `req_v_i`; it has no dependence on `resp_ready_i`.
- Latency from accept at cycle T:
  - Write or errored read: `resp_v_o` at T+1.
  - Good read: `resp_v_o` at T+2.
- Throughput: at most one access per 2 cycles (write) or 3 cycles (read) when the response is taken immediately.
- A response stalls indefinitely while `resp_ready_i` is low; the decoder stays idle.

## Configuration
- `ETH_MMIO_ARB_LOCK_EN` defined: the `req_lock_i` inputs are honoured as described under Operation.
- `ETH_MMIO_ARB_LOCK_EN` undefined:
  - `req_lock_i` is ignored.
  - `lock_v_r` is not implemented and reads as 0.
  - Arbitration is pure round-robin.

## Test plan
- Requester 0 writes 0x40 to 0x1028 with `resp_ready_i`=1 -> `dec_write_en_o` pulses for 1 cycle with `dec_write_data_o`=0x40; `resp_v_o[0]` at T+1 with `resp_err_o`=0.
- Requester 1 reads 0x1050 with the decoder returning 0xDEAD_BEEF -> `dec_read_en_o` pulses 1 cycle; `resp_v_o[1]` at T+2 with `resp_data_o`=0xDEAD_BEEF and `resp_err_o`=0.
- Both requesters hold reads of 0x0000 from reset -> grants alternate 0,1,0,1; each `dec_read_en_o` pulse is separated by at least 3 cycles.
- Read of 0x2000 with the decoder asserting `dec_error_i` -> `resp_v_o` at T+1 with `resp_err_o`=1 and `resp_data_o`=0.
- With `ETH_MMIO_ARB_LOCK_EN`: requester 0 writes 0x1028 with lock, then 0x1018 without lock, while requester 1 requests continuously -> requester 1 is granted only after the 0x1018 accept. Without the macro, requester 1 is granted between the two writes.
- Assert `reset_n_i`=0 while in RESP with `resp_ready_i`=0 -> `resp_v_o`=0 immediately; after release, the next request is granted from IDLE with `rr_r`=0.

Source files
------------

// File: rtl/ethernet_mmio_arbiter_if.sv
// ethernet_mmio_arbiter_if
//   Bundles the requester-side and decoder-side signals of the Ethernet MMIO
//   arbiter. Signal suffixes are written from the arbiter's point of view.
//   The slave modport is used by the arbiter. The master modport is used by
//   the surrounding logic, which contains the requesters and the decoder.
//   Requester k uses slice k of every packed request field.
interface ethernet_mmio_arbiter_if #(
  parameter int unsigned data_width_p = 32,
  parameter int unsigned addr_width_p = 16
);
  logic [1:0]                  req_v_i;
  logic [1:0]                  req_ready_o;
  logic [1:0]                  req_we_i;
  logic [1:0]                  req_lock_i;
  logic [2*addr_width_p-1:0]   req_addr_i;
  logic [3:0]                  req_op_size_i;
  logic [2*data_width_p-1:0]   req_data_i;
  logic [1:0]                  resp_v_o;
  logic [1:0]                  resp_ready_i;
  logic [data_width_p-1:0]     resp_data_o;
  logic                        resp_err_o;
  logic [addr_width_p-1:0]     dec_addr_o;
  logic [1:0]                  dec_op_size_o;
  logic [data_width_p-1:0]     dec_write_data_o;
  logic                        dec_write_en_o;
  logic                        dec_read_en_o;
  logic [data_width_p-1:0]     dec_read_data_i;
  logic                        dec_read_data_v_i;
  logic                        dec_error_i;

  modport slave (
    input  req_v_i, req_we_i, req_lock_i, req_addr_i, req_op_size_i, req_data_i,
    input  resp_ready_i, dec_read_data_i, dec_read_data_v_i, dec_error_i,
    output req_ready_o, resp_v_o, resp_data_o, resp_err_o,
    output dec_addr_o, dec_op_size_o, dec_write_data_o, dec_write_en_o, dec_read_en_o
  );

  modport master (
    output req_v_i, req_we_i, req_lock_i, req_addr_i, req_op_size_i, req_data_i,
    output resp_ready_i, dec_read_data_i, dec_read_data_v_i, dec_error_i,
    input  req_ready_o, resp_v_o, resp_data_o, resp_err_o,
    input  dec_addr_o, dec_op_size_o, dec_write_data_o, dec_write_en_o, dec_read_en_o
  );
endinterface

// File: rtl/ethernet_mmio_arbiter.sv
// ethernet_mmio_arbiter
//   Two-requester arbiter and sequencer in front of the Ethernet MMIO decoder.
//   The block grants one access at a time and pulses the decoder's write or
//   read enable for exactly one cycle. It captures the decode error and the
//   read data, which arrives one cycle late. It then holds the response until
//   the owning requester accepts it.
// Ports:
//   clk_i      clock
//   reset_n_i  asynchronous active-low reset
//   bus        ethernet_mmio_arbiter_if.slave (request, response and decoder signals)
// Configuration:
//   ETH_MMIO_ARB_LOCK_EN  when defined, req_lock_i keeps the grant with its owner.
//                         Otherwise arbitration is pure round-robin.
module ethernet_mmio_arbiter #(
  parameter int unsigned data_width_p = 32,
  parameter int unsigned addr_width_p = 16
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  ethernet_mmio_arbiter_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    rr_q, rr_d;
  logic                    owner_q, owner_d;
  logic [data_width_p-1:0] data_q, data_d;
  logic                    err_q, err_d;
  logic                    lock_v;

  logic                    grant_v;
  logic                    grant_k;
  logic                    accept;
  logic [addr_width_p-1:0] sel_addr;
  logic [data_width_p-1:0] sel_data;
  logic [1:0]              sel_size;
  logic                    sel_we;

`ifdef ETH_MMIO_ARB_LOCK_EN
  logic lock_v_q, lock_v_d;
  logic sel_lock;
  assign lock_v   = lock_v_q;
  assign sel_lock = bus.req_lock_i[grant_k];
`else
  logic unused_lock;
  assign lock_v      = 1'b0;
  assign unused_lock = ^bus.req_lock_i;
`endif

  // A held lock pins the grant to its owner even when the owner is idle.
  always_comb begin
    grant_v = 1'b0;
    grant_k = 1'b0;
    if (lock_v) begin
      grant_k = owner_q;
      grant_v = bus.req_v_i[owner_q];
    end else begin
      unique case (bus.req_v_i)
        2'b01:   begin grant_v = 1'b1; grant_k = 1'b0; end
        2'b10:   begin grant_v = 1'b1; grant_k = 1'b1; end
        2'b11:   begin grant_v = 1'b1; grant_k = rr_q; end
        default: begin grant_v = 1'b0; grant_k = 1'b0; end
      endcase
    end
  end

  // Gating the accept with the reset input keeps the enables and the ready
  // signals low for as long as reset is asserted.
  assign accept   = reset_n_i && (state_q == IDLE) && grant_v;
  assign sel_addr = grant_k ? bus.req_addr_i[2*addr_width_p-1:addr_width_p]
                            : bus.req_addr_i[addr_width_p-1:0];
  assign sel_data = grant_k ? bus.req_data_i[2*data_width_p-1:data_width_p]
                            : bus.req_data_i[data_width_p-1:0];
  assign sel_size = grant_k ? bus.req_op_size_i[3:2] : bus.req_op_size_i[1:0];
  assign sel_we   = bus.req_we_i[grant_k];

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      owner_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

`ifdef ETH_MMIO_ARB_LOCK_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lock_v_q <= 1'b0;
    end else begin
      lock_v_q <= lock_v_d;
    end
  end
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    data_d  = data_q;
    err_d   = err_q;
`ifdef ETH_MMIO_ARB_LOCK_EN
    lock_v_d = lock_v_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d = grant_k;
          rr_d    = ~grant_k;
`ifdef ETH_MMIO_ARB_LOCK_EN
          lock_v_d = sel_lock;
`endif
          // A write, or a read that fails to decode, completes right away.
          // No read data will follow in these cases.
          if (sel_we || bus.dec_error_i) begin
            err_d   = bus.dec_error_i;
            data_d  = '0;
            state_d = RESP;
          end else begin
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        // If no read-valid arrives in this cycle, the response is an error.
        if (bus.dec_read_data_v_i) begin
          data_d = bus.dec_read_data_i;
          err_d  = 1'b0;
        end else begin
          data_d = '0;
          err_d  = 1'b1;
        end
        state_d = RESP;
      end
      RESP: begin
        if (bus.resp_ready_i[owner_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.req_ready_o      = '0;
    bus.dec_addr_o       = '0;
    bus.dec_op_size_o    = '0;
    bus.dec_write_data_o = '0;
    bus.dec_write_en_o   = 1'b0;
    bus.dec_read_en_o    = 1'b0;
    bus.resp_v_o         = '0;
    bus.resp_data_o      = '0;
    bus.resp_err_o       = 1'b0;
    if (accept) begin
      bus.req_ready_o[grant_k] = 1'b1;
      bus.dec_addr_o           = sel_addr;
      bus.dec_op_size_o        = sel_size;
      bus.dec_write_data_o     = sel_data;
      bus.dec_write_en_o       = sel_we;
      bus.dec_read_en_o        = ~sel_we;
    end
    if (state_q == RESP) begin
      bus.resp_v_o[owner_q] = 1'b1;
      bus.resp_data_o       = data_q;
      bus.resp_err_o        = err_q;
    end
  end

endmodule

// File: tb/tb_ethernet_mmio_arbiter.sv
module tb_ethernet_mmio_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ethernet_mmio_arbiter_if #(.data_width_p(DW), .addr_width_p(AW)) bus ();

  ethernet_mmio_arbiter #(.data_width_p(DW), .addr_width_p(AW)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  // Decoder model. Address 0x2000 fails to decode. Read data arrives one cycle
  // after the read enable. The drop input suppresses the read-valid.
  logic        drop  = 1'b0;
  logic        rdv_q = 1'b0;
  logic [31:0] rdd_q = '0;
  assign bus.dec_error_i       = (bus.dec_read_en_o | bus.dec_write_en_o) && (bus.dec_addr_o == 16'h2000);
  assign bus.dec_read_data_v_i = rdv_q;
  assign bus.dec_read_data_i   = rdd_q;
  always @(posedge clk) begin
    rdv_q <= bus.dec_read_en_o && !bus.dec_error_i && !drop;
    rdd_q <= (bus.dec_addr_o == 16'h1050) ? 32'hDEADBEEF : {16'hC0DE, bus.dec_addr_o};
  end

  typedef struct {
    logic [1:0]  rv, we, rr;
    logic        drp;
    logic [15:0] a0, a1;
    logic [31:0] d0, d1;
    logic [1:0]  e_rdy;
    logic        e_wen, e_ren;
    logic [15:0] e_addr;
    logic [31:0] e_wdata;
    logic [1:0]  e_rsv;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [127:0] snap();
    return {39'b0, bus.req_ready_o, bus.dec_write_en_o, bus.dec_read_en_o, bus.dec_addr_o,
            bus.dec_op_size_o, bus.dec_write_data_o, bus.resp_v_o, bus.resp_data_o, bus.resp_err_o};
  endfunction

  // Op size is fixed at 01 for requester 0 and 10 for requester 1.
  function automatic logic [127:0] expect_of(input vec_t v);
    logic [1:0] sz;
    sz = (v.e_rdy == 2'b01) ? 2'b01 : (v.e_rdy == 2'b10) ? 2'b10 : 2'b00;
    return {39'b0, v.e_rdy, v.e_wen, v.e_ren, v.e_addr, sz, v.e_wdata, v.e_rsv, v.e_rdata, v.e_err};
  endfunction

  task automatic drive(input logic [1:0] rv, input logic [1:0] we, input logic [1:0] lk,
                       input logic [1:0] rr, input logic [15:0] a0, input logic [15:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
    bus.req_v_i       = rv;
    bus.req_we_i      = we;
    bus.req_lock_i    = lk;
    bus.resp_ready_i  = rr;
    bus.req_addr_i    = {a1, a0};
    bus.req_data_i    = {d1, d0};
    bus.req_op_size_i = 4'b1001;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t        vec [14];
  int          gk[$];
  int          gc[$];
  logic [15:0] order[$];
  logic [15:0] exp_order [3];
  int          idx0;
  logic        done1;
  logic        v0;

  initial begin
    //              rv     we     rr     drp   a0        a1        d0            d1             rdy    wen   ren   addr      wdata         rsv    rdata         err
    vec[0]  = '{2'b01, 2'b01, 2'b11, 1'b0, 16'h1028, 16'h0000, 32'h40,       32'h0,         2'b01, 1'b1, 1'b0, 16'h1028, 32'h40,       2'b00, 32'h0,        1'b0};
    vec[1]  = '{2'b00, 2'b00, 2'b11, 1'b0, 16'h1028, 16'h0000, 32'h40,       32'h0,         2'b00, 1'b0, 1'b0, 16'h0000, 32'h0,        2'b01, 32'h0,        1'b0};
    vec[2]  = '{2'b10, 2'b00, 2'b11, 1'b0, 16'h0000, 16'h1050, 32'h0,        32'h11111111,  2'b10, 1'b0, 1'b1, 16'h1050, 32'h11111111, 2'b00, 32'h0,        1'b0};
    vec[3]  = '{2'b00, 2'b00, 2'b11, 1'b0, 16'h0000, 16'h1050, 32'h0,        32'h0,         2'b00, 1'b0, 1'b0, 16'h0000, 32'h0,        2'b00, 32'h0,        1'b0};
    vec[4]  = '{2'b00, 2'b00, 2'b10, 1'b0, 16'h0000, 16'h1050, 32'h0,        32'h0,         2'b00, 1'b0, 1'b0, 16'h0000, 32'h0,        2'b10, 32'hDEADBEEF, 1'b0};
    vec[5]  = '{2'b01, 2'b00, 2'b11, 1'b0, 16'h2000, 16'h0000, 32'h0,        32'h0,         2'b01, 1'b0, 1'b1, 16'h2000, 32'h0,        2'b00, 32'h0,        1'b0};
    vec[6]  = '{2'b00, 2'b00, 2'b00, 1'b0, 16'h0000, 16'h0000, 32'h0,        32'h0,         2'b00, 1'b0, 1'b0, 16'h0000, 32'h0,        2'b01, 32'h0,        1'b1};
    vec[7]  = '{2'b10, 2'b00, 2'b00, 1'b0, 16'h0000, 16'h1050, 32'h0,        32'h0,         2'b00, 1'b0, 1'b0, 16'h0000, 32'h0,        2'b01, 32'h0,        1'b1};
    vec[8]  = '{2'b10, 2'b00, 2'b01, 1'b0, 16'h0000, 16'h1050, 32'h0,        32'h0,         2'b00, 1'b0, 1'b0, 16'h0000, 32'h0,        2'b01, 32'h0,        1'b1};
    vec[9]  = '{2'b10, 2'b10, 2'b11, 1'b0, 16'h0000, 16'h1050, 32'h0,        32'h12345678,  2'b10, 1'b1, 1'b0, 16'h1050, 32'h12345678, 2'b00, 32'h0,        1'b0};
    vec[10] = '{2'b00, 2'b00, 2'b10, 1'b0, 16'h0000, 16'h0000, 32'h0,        32'h0,         2'b00, 1'b0, 1'b0, 16'h0000, 32'h0,        2'b10, 32'h0,        1'b0};
    vec[11] = '{2'b01, 2'b00, 2'b11, 1'b1, 16'h0000, 16'h0000, 32'h0,        32'h0,         2'b01, 1'b0, 1'b1, 16'h0000, 32'h0,        2'b00, 32'h0,        1'b0};
    vec[12] = '{2'b00, 2'b00, 2'b11, 1'b1, 16'h0000, 16'h0000, 32'h0,        32'h0,         2'b00, 1'b0, 1'b0, 16'h0000, 32'h0,        2'b00, 32'h0,        1'b0};
    vec[13] = '{2'b00, 2'b00, 2'b01, 1'b0, 16'h0000, 16'h0000, 32'h0,        32'h0,         2'b00, 1'b0, 1'b0, 16'h0000, 32'h0,        2'b01, 32'h0,        1'b1};

    // Outputs during reset, with both requesters asserting.
    rst_n = 1'b0;
    drive(2'b11, 2'b00, 2'b00, 2'b11, 16'h1028, 16'h1050, 32'h1, 32'h2);
    @(negedge clk);
    check("reset_outputs", snap(), 128'h0);
    drive(2'b00, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 32'h0, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Cycle-by-cycle vectors
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      drop = vec[i].drp;
      drive(vec[i].rv, vec[i].we, 2'b00, vec[i].rr, vec[i].a0, vec[i].a1, vec[i].d0, vec[i].d1);
      @(negedge clk);
      check($sformatf("vec%0d", i), snap(), expect_of(vec[i]));
    end
    drop = 1'b0;

    // Both requesters hold reads of 0x0000: grants alternate and are 3 cycles apart.
    rst_n = 1'b0;
    drive(2'b11, 2'b00, 2'b00, 2'b11, 16'h0, 16'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.req_ready_o != 2'b00) begin
        gk.push_back(int'(bus.req_ready_o[1]));
        gc.push_back(c);
        check("rr_read_en", {127'b0, bus.dec_read_en_o}, 128'h1);
      end
    end
    check("rr_grant_count", gk.size() >= 4 ? 128'h1 : 128'h0, 128'h1);
    for (int i = 0; i < 4; i++) begin
      if (i < gk.size()) check($sformatf("rr_grant%0d", i), gk[i], i % 2);
    end
    for (int i = 0; i < 3; i++) begin
      if (i + 1 < gc.size()) check($sformatf("rr_gap%0d", i), (gc[i+1] - gc[i]) >= 3 ? 128'h1 : 128'h0, 128'h1);
    end
    drive(2'b00, 2'b00, 2'b00, 2'b11, 16'h0, 16'h0, 32'h0, 32'h0);

    // Lock: requester 0 writes 0x1028 with lock, stays idle, and then writes
    // 0x1018 without lock. Requester 1 keeps requesting a write of 0x3000.
    do_reset();
    idx0  = 0;
    done1 = 1'b0;
    for (int c = 0; c < 30 && (idx0 < 2 || !done1); c++) begin
      v0 = (idx0 == 0) || (idx0 == 1 && c >= 6);
      drive({~done1, v0 && (idx0 < 2)}, 2'b11, {1'b0, idx0 == 0}, 2'b11,
            (idx0 == 0) ? 16'h1028 : 16'h1018, 16'h3000, 32'h40, 32'h99);
      @(negedge clk);
      if (bus.req_ready_o[0]) begin order.push_back(bus.dec_addr_o); idx0++; end
      if (bus.req_ready_o[1]) begin order.push_back(bus.dec_addr_o); done1 = 1'b1; end
      @(posedge clk);
      #1;
    end
`ifdef ETH_MMIO_ARB_LOCK_EN
    exp_order = '{16'h1028, 16'h1018, 16'h3000};
`else
    exp_order = '{16'h1028, 16'h3000, 16'h1018};
`endif
    check("lock_accept_count", order.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < order.size()) check($sformatf("lock_order%0d", i), order[i], exp_order[i]);
    end
    drive(2'b00, 2'b00, 2'b00, 2'b11, 16'h0, 16'h0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);

    // Reset while a response is stalled.
    do_reset();
    drive(2'b01, 2'b01, 2'b00, 2'b00, 16'h1028, 16'h0, 32'h40, 32'h0);
    @(negedge clk);
    check("mid_accept", bus.req_ready_o, 2'b01);
    @(posedge clk);
    #1 drive(2'b11, 2'b11, 2'b00, 2'b00, 16'h1028, 16'h1050, 32'h40, 32'h5);
    @(negedge clk);
    check("mid_resp_hold", {bus.resp_v_o, bus.req_ready_o}, 4'b0100);
    #2 rst_n = 1'b0;
    #1 check("mid_reset_async", {bus.resp_v_o, bus.req_ready_o, bus.dec_write_en_o, bus.dec_read_en_o}, 6'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("mid_after_reset", {bus.req_ready_o, bus.dec_write_en_o, bus.dec_addr_o}, {2'b01, 1'b1, 16'h1028});

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
